// File: rtl/apb_master.sv
// APB initiator: buffers processor commands in a small circular FIFO and runs
// them one at a time as APB transfers, returning one response pulse per command.
module apb_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [31:0]                   cmd_addr,
    input  logic [31:0]                   cmd_wdata,
    output logic                          rsp_valid,
    output logic                          rsp_write,
    output logic [31:0]                   rsp_rdata,
    output logic                          rsp_err,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [31:0]                   paddr,
    output logic [31:0]                   pwdata,
    input  logic                          valid,
    input  logic [31:0]                   prdata,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    dbg_state
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int TW    = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0]    TO_LAST  = TW'(RD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RWAIT  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [64:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TW-1:0]    wait_q, wait_d;
    logic             psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [31:0]      paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             full, empty, push, pop;
    logic [64:0]      head;

    // Handshakes: a command moves on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready depends only on registered occupancy. rsp_valid is a one-cycle
    // pulse with no ready, so the requester must take it when it appears.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = cmd_valid && !full;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = head[64];
                    paddr_d   = head[63:32];
                    pwdata_d  = head[31:0];
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (pwrite_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    wait_d  = '0;
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                // A late valid still wins over the timeout in the final wait cycle.
                if (valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = prdata;
                    state_d     = S_IDLE;
                end else if (wait_q == TO_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'hFFFF_FFFF;
                    state_d     = S_IDLE;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    assign cmd_ready  = !full;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_write  = rsp_write_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign fifo_count = count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: APB memory responder, command driver, and scoreboards
// for APB issue order and responses against a simple memory reference model.
module tb_apb_master;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        valid;
    logic [31:0] prdata;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [1:0]  dbg_state;

    // clock / reset
    always #5 clk = ~clk;

    apb_master #(.FIFO_DEPTH(DEPTH), .RD_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .valid(valid), .prdata(prdata),
        .busy(busy), .fifo_count(fifo_count), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    logic [33:0] exp_q[$];   // {write, err, rdata}
    logic [64:0] apb_q[$];   // {write, addr, wdata}
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] resp_mem [logic [31:0]];
    bit          resp_en = 1'b1;
    int          rd_lat = 0;
    int          model_cnt = 0;
    bit          saw_full = 1'b0;
    logic [31:0] last_addr, last_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // driver: holds the command until accepted, then updates the reference model
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit   done = 1'b0;
        logic rdy;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1'b1;
                model_cnt++;
                apb_q.push_back({w, a, d});
                if (w) begin
                    ref_mem[a] = d;
                    exp_q.push_back({1'b1, 1'b0, 32'h0});
                end else if (resp_en) begin
                    exp_q.push_back({1'b0, 1'b0, ref_rd(a)});
                end else begin
                    exp_q.push_back({1'b0, 1'b1, 32'hFFFF_FFFF});
                end
            end
        end
        #1 cmd_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_accept actual=not_accepted expected=accepted addr=%0h", a);
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 2000 && !idle; i++) begin
            @(posedge clk);
            idle = (exp_q.size() == 0) && (apb_q.size() == 0) && !busy;
        end
        #1;
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending expected=0", exp_q.size());
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        apb_q.delete();
        model_cnt = 0;
    endtask

    // APB memory responder: read data appears the edge after the ACCESS cycle (+rd_lat)
    initial begin : responder
        bit          pend = 1'b0;
        bit          pend_en = 1'b1;
        int          pend_lat = 0;
        logic [31:0] pend_data = '0;
        valid  = 1'b0;
        prdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
            end else if (psel && penable) begin
                if (pwrite) begin
                    resp_mem[paddr] = pwdata;
                end else begin
                    pend      = 1'b1;
                    pend_en   = resp_en;
                    pend_lat  = rd_lat;
                    pend_data = resp_mem.exists(paddr) ? resp_mem[paddr] : 32'h0;
                end
            end
            @(posedge clk);
            #1;
            valid = 1'b0;
            if (pend && rst) begin
                if (pend_lat == 0) begin
                    valid  = pend_en;
                    prdata = pend_data;
                    pend   = 1'b0;
                end else begin
                    pend_lat--;
                end
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (psel && !penable) begin
                model_cnt--;
                if (apb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_setup actual=%0h expected=none", paddr);
                end else begin
                    logic [64:0] e;
                    e = apb_q.pop_front();
                    chk("setup_pwrite", pwrite, e[64]);
                    chk("setup_paddr", paddr, e[63:32]);
                    chk("setup_pwdata", pwdata, e[31:0]);
                end
                last_addr  = paddr;
                last_wdata = pwdata;
            end
            if (psel && penable) begin
                chk("access_paddr", paddr, last_addr);
                chk("access_pwdata", pwdata, last_wdata);
            end
            chk("fifo_count", fifo_count, model_cnt);
            chk("cmd_ready", cmd_ready, (model_cnt < DEPTH) ? 1 : 0);
            if (model_cnt == DEPTH) saw_full = 1'b1;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=rsp_valid expected=none rdata=%0h", rsp_rdata);
                end else begin
                    logic [33:0] r;
                    r = exp_q.pop_front();
                    chk("rsp_write", rsp_write, r[33]);
                    chk("rsp_err", rsp_err, r[32]);
                    if (!r[33]) chk("rsp_rdata", rsp_rdata, r[31:0]);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"}, psel, 0);
        chk({tag, "_penable"}, penable, 0);
        chk({tag, "_pwrite"}, pwrite, 0);
        chk({tag, "_paddr"}, paddr, 0);
        chk({tag, "_pwdata"}, pwdata, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_write"}, rsp_write, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin : main
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        #2;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // write then read with exact phase timing
        push(1'b1, 32'd5, 32'hA5A5_0F0F);
        chk("wr_n0_psel", psel, 0);
        @(posedge clk); #1;
        chk("wr_n1_psel", psel, 1);
        chk("wr_n1_penable", penable, 0);
        chk("wr_n1_pwrite", pwrite, 1);
        chk("wr_n1_paddr", paddr, 32'd5);
        @(posedge clk); #1;
        chk("wr_n2_psel", psel, 1);
        chk("wr_n2_penable", penable, 1);
        @(posedge clk); #1;
        chk("wr_n3_psel", psel, 0);
        chk("wr_n3_penable", penable, 0);
        chk("wr_n3_rsp_valid", rsp_valid, 1);
        chk("wr_n3_rsp_write", rsp_write, 1);
        @(posedge clk); #1;
        chk("wr_n4_rsp_valid", rsp_valid, 0);
        push(1'b0, 32'd5, 32'h0);
        @(posedge clk); #1;
        chk("rd_n1_psel", psel, 1);
        chk("rd_n1_pwrite", pwrite, 0);
        @(posedge clk); #1;
        chk("rd_n2_penable", penable, 1);
        @(posedge clk); #1;
        chk("rd_n3_psel", psel, 0);
        chk("rd_n3_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        chk("rd_n4_rsp_valid", rsp_valid, 1);
        chk("rd_n4_rsp_write", rsp_write, 0);
        chk("rd_n4_rsp_err", rsp_err, 0);
        chk("rd_n4_rsp_rdata", rsp_rdata, 32'hA5A5_0F0F);
        wait_idle();

        // FIFO fill behind a slow read
        saw_full = 1'b0;
        rd_lat = 5;
        push(1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 5; i++) push(1'b1, i, $urandom);
        wait_idle();
        rd_lat = 0;
        chk("fifo_reached_full", saw_full, 1);

        // pointer wrap: alternating write/read
        for (int i = 0; i < 10; i++) begin
            push(1'b1, i, $urandom);
            push(1'b0, i, $urandom);
        end
        wait_idle();

        // read timeout
        resp_en = 1'b0;
        push(1'b0, 32'd3, 32'h0);
        repeat (10) @(posedge clk);
        #1 chk("to_early_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
        wait_idle();
        resp_en = 1'b1;
        push(1'b1, 32'd3, 32'h1234_5678);
        push(1'b0, 32'd3, 32'h0);
        wait_idle();

        // randomized traffic with variable read latency
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            rd_lat = $urandom_range(0, 3);
            push(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
        end
        wait_idle();
        rd_lat = 0;

        // reset during SETUP of a read with two commands queued
        push(1'b1, 32'd7, 32'hCAFE_0007);
        push(1'b0, 32'd7, 32'h0);
        push(1'b0, 32'd1, 32'h0);
        push(1'b0, 32'd2, 32'h0);
        @(posedge clk); #1;
        chk("pre_rst_psel", psel, 1);
        chk("pre_rst_penable", penable, 0);
        chk("pre_rst_pwrite", pwrite, 0);
        chk("pre_rst_paddr", paddr, 32'd7);
        chk("pre_rst_count", fifo_count, 2);
        rst = 1'b0;
        flush_model();
        #1;
        chk_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_count", fifo_count, 0);
        push(1'b0, 32'd7, 32'h0);
        wait_idle();

        chk("final_exp_q_empty", exp_q.size(), 0);
        chk("final_apb_q_empty", apb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

Initiator side of the team's APB link. Accepts read/write commands from a processor-side requester into a small command FIFO and drives them one at a time onto psel/penable/pwrite/paddr/pwdata toward the APB memory responder. For each transfer it returns a one-cycle response pulse, carrying read data captured when the responder raises `valid`, or an error flag if `valid` never arrives.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `RD_TIMEOUT`, 8: maximum RWAIT cycles before a read is failed; ≥1.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-low; the block is in reset while `rst`=0.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the FIFO can accept a command; equals !full, from registered count.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 32: target word address.
- `cmd_wdata` in 32: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse per completed transfer; no backpressure.
- `rsp_write` out 1: echoes the command type of the response.
- `rsp_rdata` out 32: read data; held until the next response.
- `rsp_err` out 1: read timeout; valid with `rsp_valid`.
- `psel`, `penable`, `pwrite` out 1 each: APB control, registered.
- `paddr`, `pwdata` out 32 each: APB address/data, registered, held stable from SETUP through ACCESS.
- `valid` in 1: responder read-data-valid strobe.
- `prdata` in 32: responder read data.
- `busy` out 1: state≠IDLE or FIFO non-empty.
- `fifo_count` out log2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Push on `cmd_valid && cmd_ready`. Stores {write, addr, wdata}. The FIFO uses a circular buffer: read and write pointers wrap modulo FIFO_DEPTH, and the count saturates at neither end because push is gated by full and pop by empty.
- A push and pop in the same cycle leave the count unchanged. When full, `cmd_ready`=0 even in a pop cycle.
- FSM states:
  - IDLE: `psel`=0, `penable`=0. If the FIFO is non-empty, pop the head, load `paddr`/`pwrite`/`pwdata`, set `psel`=1, and go to SETUP.
  - SETUP: set `penable`=1 and go to ACCESS.
  - ACCESS: clear `psel` and `penable`. For a write, pulse `rsp_valid` with `rsp_write`=1 and `rsp_err`=0, then go to IDLE. For a read, clear the wait counter and go to RWAIT.
  - RWAIT: if `valid`=1, set `rsp_rdata`←`prdata`, `rsp_err`=0, pulse `rsp_valid`, and go to IDLE. Otherwise increment the counter. When the counter reaches RD_TIMEOUT-1 with no `valid`, set `rsp_rdata`=32'hFFFF_FFFF, `rsp_err`=1, pulse `rsp_valid`, and go to IDLE.
- `valid` and `prdata` are ignored outside RWAIT.
- `pwdata` is don't-care for reads but still driven from the FIFO entry.
- Exactly one outstanding APB transfer at a time; responses are returned in command order.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - all outputs to 0, including `rsp_rdata`, `paddr`, and `pwdata`;
  - `cmd_ready`=1;
  - state IDLE;
  - FIFO pointers and count to 0.
- Reset mid-transfer aborts the transfer, drops any pending response, and flushes the FIFO. There is no response for aborted commands.
- Take a command accepted at edge N into an empty, idle block:
  - after edge N+1: `psel`=1, `penable`=0;
  - after edge N+2: `penable`=1;
  - after edge N+3: `psel`=`penable`=0;
  - write: `rsp_valid` is high between edges N+3 and N+4.
  - read: the responder registers `valid`/`prdata` at edge N+3, the block samples them at edge N+4, and `rsp_valid` is high between edges N+4 and N+5.
- Throughput with a full FIFO:
  - a write occupies 3 cycles (IDLE, SETUP, ACCESS);
  - a read with prompt `valid` occupies 4 cycles;
  - `psel` is low for at least one cycle between transfers.
- Timeout: with `valid` held 0, `rsp_valid`/`rsp_err` rise RD_TIMEOUT cycles after entering RWAIT.

## Test plan
- Write then read: write addr 5 / data 32'hA5A5_0F0F, then read addr 5.
  - Expect the APB phases exactly as in Timing.
  - Expect two `rsp_valid` pulses: `rsp_write`=1, then `rsp_write`=0 with `rsp_rdata`=32'hA5A5_0F0F and `rsp_err`=0.
- FIFO fill: push 5 writes with `cmd_valid` held and APB idle-blocked by the first transfer.
  - Expect `cmd_ready`=0 once `fifo_count`=4 (FIFO_DEPTH=4).
  - Expect all 5 writes issued in order to addresses 0..4 with no loss or duplication.
- Pointer wrap: stream 10 alternating writes/reads to addresses 0..9.
  - Expect the FIFO pointers to wrap.
  - Expect every read response to echo the data written to the same address.
- Read timeout: tie `valid`=0 and read addr 3.
  - Expect `rsp_valid` 8 cycles after entering RWAIT, with `rsp_err`=1 and `rsp_rdata`=32'hFFFF_FFFF.
  - Expect the next command to proceed normally.
- Reset mid-transfer: assert `rst`=0 during SETUP of a read with 2 commands queued.
  - Expect all outputs to drop to 0 immediately and `fifo_count`=0.
  - Expect no `rsp_valid` after release, `busy`=0, and `cmd_ready`=1.
